// File: rtl/cfg_ext_req_pkg.sv
// Shared types for the cfg_ext requester: FSM states, response record, field widths.
// The optional statistics block is enabled by CFG_EXT_REQ_STATS_EN.
package cfg_ext_req_pkg;

    localparam int CFG_EXT_REG_W  = 10;
    localparam int CFG_EXT_FUNC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } cfg_ext_req_state_e;

    typedef struct packed {
        logic        write;
        logic        timeout;
        logic [31:0] data;
    } cfg_ext_rsp_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        sat_inc16 = (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cfg_ext_req_stats.sv
// Saturating 16-bit event counters for the cfg_ext requester.
// Only instantiated when CFG_EXT_REQ_STATS_EN is defined.
module cfg_ext_req_stats
    import cfg_ext_req_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stat_clear,
    input  logic        inc_read,
    input  logic        inc_write,
    input  logic        inc_timeout,
    input  logic        inc_stray,
    output logic [15:0] stat_reads,
    output logic [15:0] stat_writes,
    output logic [15:0] stat_timeouts,
    output logic [15:0] stat_stray_valid
);

    logic [15:0] reads_r;
    logic [15:0] writes_r;
    logic [15:0] timeouts_r;
    logic [15:0] stray_r;

    // Counter registers: async reset, synchronous clear, saturating increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reads_r    <= 16'd0;
            writes_r   <= 16'd0;
            timeouts_r <= 16'd0;
            stray_r    <= 16'd0;
        end else if (stat_clear) begin
            reads_r    <= 16'd0;
            writes_r   <= 16'd0;
            timeouts_r <= 16'd0;
            stray_r    <= 16'd0;
        end else begin
            reads_r    <= inc_read    ? sat_inc16(reads_r)    : reads_r;
            writes_r   <= inc_write   ? sat_inc16(writes_r)   : writes_r;
            timeouts_r <= inc_timeout ? sat_inc16(timeouts_r) : timeouts_r;
            stray_r    <= inc_stray   ? sat_inc16(stray_r)    : stray_r;
        end
    end

    assign stat_reads       = reads_r;
    assign stat_writes      = writes_r;
    assign stat_timeouts    = timeouts_r;
    assign stat_stray_valid = stray_r;

endmodule

// File: rtl/cfg_ext_requester.sv
// cfg_ext initiator: single read/write commands in, strobed cfg_ext requests out, bounded read wait.
// Define CFG_EXT_REQ_STATS_EN to add the stat_* counter ports.
module cfg_ext_requester
    import cfg_ext_req_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [CFG_EXT_REG_W-1:0]  req_register_number,
    input  logic [CFG_EXT_FUNC_W-1:0] req_function_number,
    input  logic [31:0]               req_write_data,
    input  logic [3:0]                req_byte_enable,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic                      rsp_timeout,
    output logic [31:0]               rsp_data,
    output logic                      cfg_ext_read_received,
    output logic                      cfg_ext_write_received,
    output logic [CFG_EXT_REG_W-1:0]  cfg_ext_register_number,
    output logic [CFG_EXT_FUNC_W-1:0] cfg_ext_function_number,
    output logic [31:0]               cfg_ext_write_data,
    output logic [3:0]                cfg_ext_write_byte_enable,
    input  logic [31:0]               cfg_ext_read_data,
    input  logic                      cfg_ext_read_data_valid,
    output logic                      busy
`ifdef CFG_EXT_REQ_STATS_EN
    ,
    input  logic                      stat_clear,
    output logic [15:0]               stat_reads,
    output logic [15:0]               stat_writes,
    output logic [15:0]               stat_timeouts,
    output logic [15:0]               stat_stray_valid
`endif
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    cfg_ext_req_state_e        state_r;
    cfg_ext_req_state_e        state_next_s;
    logic                      accept_s;
    logic                      capture_s;
    logic                      expire_s;
    logic [7:0]                wait_cnt_r;
    cfg_ext_rsp_t              rsp_r;
    logic                      ready_r;
    logic                      busy_r;
    logic                      rsp_valid_r;
    logic                      rd_strobe_r;
    logic                      wr_strobe_r;
    logic [CFG_EXT_REG_W-1:0]  reg_num_r;
    logic [CFG_EXT_FUNC_W-1:0] func_num_r;
    logic [31:0]               wdata_r;
    logic [3:0]                be_r;

    // Next-state decode and single-cycle event flags.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rsp_r.write) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                // Data arriving on the expiry cycle takes priority over the timeout.
                if (cfg_ext_read_data_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else if (wait_cnt_r == TIMEOUT_LIMIT) begin
                    expire_s     = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT_RD;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags, request fields, strobes and response record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rd_strobe_r <= 1'b0;
            wr_strobe_r <= 1'b0;
            reg_num_r   <= '0;
            func_num_r  <= '0;
            wdata_r     <= 32'd0;
            be_r        <= 4'd0;
            wait_cnt_r  <= 8'd0;
            rsp_r       <= '0;
        end else begin
            state_r     <= state_next_s;
            ready_r     <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
            rd_strobe_r <= accept_s & ~req_write;
            wr_strobe_r <= accept_s & req_write & (|req_byte_enable);
            if (accept_s) begin
                reg_num_r     <= req_register_number;
                func_num_r    <= req_function_number;
                wdata_r       <= req_write_data;
                be_r          <= req_byte_enable;
                rsp_r.write   <= req_write;
                rsp_r.timeout <= 1'b0;
                rsp_r.data    <= 32'd0;
            end else if (capture_s) begin
                rsp_r.data    <= cfg_ext_read_data;
            end else if (expire_s) begin
                rsp_r.timeout <= 1'b1;
                rsp_r.data    <= TIMEOUT_DATA;
            end else begin
                rsp_r         <= rsp_r;
            end
            if (state_r == ST_ISSUE) begin
                wait_cnt_r <= 8'd1;
            end else if (state_r == ST_WAIT_RD) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // req_ready is held low while reset is asserted, high in IDLE afterwards.
    assign req_ready                 = ready_r & ~reset;
    assign busy                      = busy_r;
    assign rsp_valid                 = rsp_valid_r;
    assign rsp_write                 = rsp_r.write;
    assign rsp_timeout               = rsp_r.timeout;
    assign rsp_data                  = rsp_r.data;
    assign cfg_ext_read_received     = rd_strobe_r;
    assign cfg_ext_write_received    = wr_strobe_r;
    assign cfg_ext_register_number   = reg_num_r;
    assign cfg_ext_function_number   = func_num_r;
    assign cfg_ext_write_data        = wdata_r;
    assign cfg_ext_write_byte_enable = be_r;

`ifdef CFG_EXT_REQ_STATS_EN
    logic stray_s;
    assign stray_s = cfg_ext_read_data_valid & (state_r != ST_WAIT_RD);

    cfg_ext_req_stats u_stats (
        .clk              (clk),
        .reset            (reset),
        .stat_clear       (stat_clear),
        .inc_read         (rd_strobe_r),
        .inc_write        (wr_strobe_r),
        .inc_timeout      (expire_s),
        .inc_stray        (stray_s),
        .stat_reads       (stat_reads),
        .stat_writes      (stat_writes),
        .stat_timeouts    (stat_timeouts),
        .stat_stray_valid (stat_stray_valid)
    );
`endif

endmodule
